// File: rtl/async_req_arbiter_if.sv
// Grant-side bundle between async_req_arbiter and the clk-domain service block.
// The arbiter uses the master view; the consumer (or a bench) uses the slave view.
interface async_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] async_req;
    logic               grant_valid;
    logic [GID_W-1:0]   grant_id;
    logic               grant_ready;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] overflow;

    modport master (
        input  async_req,
        input  grant_ready,
        output grant_valid,
        output grant_id,
        output pending,
        output overflow
    );

    modport slave (
        output async_req,
        output grant_ready,
        input  grant_valid,
        input  grant_id,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/async_req_arbiter.sv
// Synchronizes NUM_REQ asynchronous request lines, turns each rising edge into a
// pending event and hands events out one at a time with round-robin fairness.
module async_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int SYNC_STAGES = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    async_req_arbiter_if.master bus
);
    localparam int GID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 32) begin : g_bad_num_req
        $error("async_req_arbiter: NUM_REQ must be in 2..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 5) begin : g_bad_sync_stages
        $error("async_req_arbiter: SYNC_STAGES must be in 2..5");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizer chains and rising-edge detect
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] sync_chain_q [SYNC_STAGES];
    logic [NUM_REQ-1:0] sync_prev_q;
    logic [NUM_REQ-1:0] sync_q;
    logic [NUM_REQ-1:0] rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the chain array is reset stage by stage so a level
    // captured before reset can never surface as an event afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_chain_q[s] <= '0;
            end
            sync_prev_q <= '0;
        end else begin
            sync_chain_q[0] <= bus.async_req;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_chain_q[s] <= sync_chain_q[s-1];
            end
            sync_prev_q <= sync_q;
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];
    assign rise   = sync_q & ~sync_prev_q;

    // ------------------------------------------------------------------
    // Pending flags, overflow pulses and grant FSM
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [GID_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] overflow_q, overflow_d;
    logic [NUM_REQ-1:0] clear;
    logic               accept;
    logic               hi_found;
    logic [GID_W-1:0]   hi_id;
    logic [GID_W-1:0]   lo_id;
    logic [GID_W-1:0]   sel_id;

    // Round-robin pick: the lowest pending index above last_grant wins, otherwise
    // the lowest pending index overall (the wrap-around case).
    always_comb begin
        hi_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lo_id = GID_W'(i);
                if (i > int'(last_grant_q)) begin
                    hi_found = 1'b1;
                    hi_id    = GID_W'(i);
                end
            end
        end
        sel_id = hi_found ? hi_id : lo_id;
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        accept       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    grant_id_d = sel_id;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (bus.grant_ready) begin
                    accept       = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A rise coinciding with acceptance re-arms the flag; a rise on a flag that
    // stays set is the only way an event is lost.
    always_comb begin
        clear = '0;
        if (accept) begin
            clear[grant_id_q] = 1'b1;
        end
        pending_d  = (pending_q & ~clear) | rise;
        overflow_d = rise & pending_q & ~clear;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GID_W'(NUM_REQ - 1);
            pending_q    <= '0;
            overflow_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.grant_valid = (state_q == S_GRANT);
    assign bus.grant_id    = grant_id_q;
    assign bus.pending     = pending_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Directed bench for async_req_arbiter: expected grant ids go into a scoreboard
// queue, a negedge monitor pops them on every accepted grant.
module tb_async_req_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int SYNC_STAGES = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_q[$];

    async_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    async_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: a grant is consumed at the next posedge when valid and ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.grant_valid === 1'b1 && bus.grant_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'(bus.grant_id), 32'hFFFF_FFFF);
            end else begin
                check("grant_id", 32'(bus.grant_id), 32'(exp_q.pop_front()));
            end
        end
    end

    // Advance n posedges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with reset released: the next posedge is edge 1.
    task automatic do_reset(input logic [NUM_REQ-1:0] req);
        rst_n            = 1'b0;
        bus.async_req    = req;
        bus.grant_ready  = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int               ov1_cnt;
        logic [NUM_REQ-1:0] ov_other;
        logic [7:0]       vbits;

        rst_n           = 1'b0;
        bus.async_req   = '0;
        bus.grant_ready = 1'b0;
        step(2);
        check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_grant_id",    32'(bus.grant_id),    32'd0);
        check("rst_pending",     32'(bus.pending),     32'd0);
        check("rst_overflow",    32'(bus.overflow),    32'd0);

        // 1: single request latency
        rst_n = 1'b1;
        bus.async_req   = 4'b0100;
        bus.grant_ready = 1'b1;
        exp_q.push_back(2);
        step(3);
        check("lat_pending_e3", 32'(bus.pending), 32'h0);
        step(1);
        check("lat_pending_e4", 32'(bus.pending), 32'h4);
        check("lat_valid_e4",   32'(bus.grant_valid), 32'd0);
        step(1);
        check("lat_valid_e5", 32'(bus.grant_valid), 32'd1);
        check("lat_id_e5",    32'(bus.grant_id),    32'd2);
        step(1);
        check("lat_valid_e6",   32'(bus.grant_valid), 32'd0);
        check("lat_pending_e6", 32'(bus.pending),     32'h0);
        bus.async_req = '0;
        step(6);

        // 2: all four together -> 0,1,2,3 with one idle cycle between grants
        do_reset('0);
        bus.async_req   = 4'b1111;
        bus.grant_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        step(4);
        check("all_pending_e4", 32'(bus.pending), 32'hF);
        bus.async_req = '0;
        for (int e = 0; e < 8; e++) begin
            step(1);
            vbits[e] = bus.grant_valid;
        end
        check("all_valid_pattern", 32'(vbits), 32'h55);
        check("all_pending_done",  32'(bus.pending), 32'h0);
        step(2);
        bus.async_req = 4'b0001;
        exp_q.push_back(0);
        step(5);
        check("wrap_valid", 32'(bus.grant_valid), 32'd1);
        check("wrap_id",    32'(bus.grant_id),    32'd0);
        bus.async_req = '0;
        step(5);

        // 3: double event while stalled -> one overflow pulse, one grant
        do_reset('0);
        ov1_cnt  = 0;
        ov_other = '0;
        for (int c = 0; c < 20; c++) begin
            bus.async_req[1] = (c < 4) || (c >= 8 && c < 12);
            step(1);
            ov1_cnt  += int'(bus.overflow[1]);
            ov_other |= bus.overflow & 4'b1101;
        end
        check("ovf_count",   32'(ov1_cnt),  32'd1);
        check("ovf_other",   32'(ov_other), 32'h0);
        check("ovf_pending", 32'(bus.pending), 32'h2);
        check("ovf_held_id", 32'(bus.grant_id), 32'd1);
        exp_q.push_back(1);
        bus.grant_ready = 1'b1;
        step(2);
        check("ovf_cleared", 32'(bus.pending),     32'h0);
        check("ovf_idle",    32'(bus.grant_valid), 32'd0);
        step(8);

        // 4: rise coincides with acceptance -> event kept, regranted after one idle
        do_reset('0);
        exp_q.push_back(0);
        exp_q.push_back(0);
        bus.async_req = 4'b0001;
        step(5);
        check("coin_valid_e5", 32'(bus.grant_valid), 32'd1);
        check("coin_id_e5",    32'(bus.grant_id),    32'd0);
        step(1);
        bus.async_req = '0;
        step(4);
        bus.async_req = 4'b0001;
        step(3);
        bus.grant_ready = 1'b1;
        step(1);
        check("coin_pending_e14",  32'(bus.pending),     32'h1);
        check("coin_valid_e14",    32'(bus.grant_valid), 32'd0);
        check("coin_overflow_e14", 32'(bus.overflow),    32'h0);
        step(1);
        check("coin_valid_e15",    32'(bus.grant_valid), 32'd1);
        check("coin_id_e15",       32'(bus.grant_id),    32'd0);
        check("coin_overflow_e15", 32'(bus.overflow),    32'h0);
        step(1);
        check("coin_pending_e16", 32'(bus.pending), 32'h0);
        bus.async_req = '0;
        step(4);

        // 5: req 3 must not starve while 0-2 re-raise
        do_reset('0);
        bus.grant_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        bus.async_req = 4'b0111;
        step(2);
        bus.async_req = 4'b1111;
        step(2);
        bus.async_req = 4'b1000;
        step(2);
        bus.async_req = 4'b1111;
        step(20);
        check("starve_pending", 32'(bus.pending), 32'h0);
        bus.async_req = '0;
        step(4);

        // 6: reset mid-operation
        do_reset('0);
        bus.async_req = 4'b1010;
        step(5);
        bus.async_req = 4'b1011;
        step(1);
        check("mid_valid_pre",   32'(bus.grant_valid), 32'd1);
        check("mid_id_pre",      32'(bus.grant_id),    32'd1);
        check("mid_pending_pre", 32'(bus.pending),     32'hA);
        rst_n = 1'b0;
        #1;
        check("mid_valid_rst",    32'(bus.grant_valid), 32'd0);
        check("mid_pending_rst",  32'(bus.pending),     32'h0);
        check("mid_overflow_rst", 32'(bus.overflow),    32'h0);
        bus.async_req   = '0;
        bus.grant_ready = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(12);
        check("mid_quiet_valid",   32'(bus.grant_valid), 32'd0);
        check("mid_quiet_pending", 32'(bus.pending),     32'h0);
        do_reset(4'b1000);
        bus.grant_ready = 1'b1;
        exp_q.push_back(3);
        step(10);
        check("held_pending", 32'(bus.pending), 32'h0);
        step(6);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/async_req_arbiter.md
Name: async_req_arbiter

Overview:
- Accepts NUM_REQ asynchronous request lines and synchronizes each through its own SYNC_STAGES-deep flop chain.
- Converts each synchronized rising edge into a single pending event.
- Arbitrates pending events round-robin and issues one grant at a time through a valid/ready handshake into the clk domain.
- Sits at the boundary between unsynchronized event sources (off-chip strobes, foreign-domain flags) and a shared clk-domain service block.

Parameters:
- NUM_REQ, 4, number of asynchronous request inputs; legal range 2..32.
- SYNC_STAGES, 3, synchronizer depth per input; legal range 2..5; out-of-range values are an elaboration error.
- GID_W, $clog2(NUM_REQ), localparam, grant_id width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- async_req  input  NUM_REQ  asynchronous request levels; a 0->1 transition is one event.
- grant_valid  output  1  grant offered.
- grant_id  output  GID_W  index of granted requester; stable while grant_valid=1.
- grant_ready  input  1  consumer accepts grant.
- pending  output  NUM_REQ  registered per-requester pending flags.
- overflow  output  NUM_REQ  one-cycle pulse per requester when an event is dropped.

Behaviour:
- Reset (async assert, sync release): all sync chains, edge-detect registers, pending, overflow and grant_valid go to 0. grant_id=0. FSM=IDLE. last_grant=NUM_REQ-1.
- Synchronizer: each bit is sampled into a SYNC_STAGES-flop chain. sync_q[i] is the last stage. An extra register sync_d[i] holds the previous sync_q[i]. rise[i] = sync_q[i] & ~sync_d[i] (combinational).
- Latency: async_req[i] first sampled high at edge 1 -> sync_q high after edge SYNC_STAGES -> pending[i] set at edge SYNC_STAGES+1 -> earliest grant_valid at edge SYNC_STAGES+2.
- Input qualification: each level (high and low) must last at least 2 clk periods to be guaranteed detected. Narrower pulses may be missed, but never produce more than one event.
- A line held high through reset release produces exactly one event after release.
- Pending update per bit, per cycle:
  - set if rise[i];
  - cleared if accepted (grant_valid & grant_ready & grant_id==i);
  - rise and clear in the same cycle -> pending stays 1 (new event kept), no overflow;
  - rise while pending=1 and not being cleared -> pending stays 1, overflow[i]=1 for exactly the next cycle, event dropped.
- FSM IDLE:
  - grant_valid=0; grant_ready is ignored.
  - If any pending bit is set, select the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - Register it into grant_id, set grant_valid=1, go to GRANT.
  - Selection uses registered pending only; events arriving the same cycle are not visible until the next cycle.
- FSM GRANT:
  - grant_valid=1; grant_id held constant.
  - On grant_valid & grant_ready: clear pending[grant_id], last_grant<=grant_id, grant_valid<=0, go to IDLE.
  - Otherwise hold indefinitely; no timeout.
- Throughput: at most one grant per 2 cycles; there is always one IDLE cycle between grants.
- Fairness: with all requesters continuously pending, each is granted once every NUM_REQ grants.
- Reset mid-operation: an outstanding grant is withdrawn immediately. Pending events and events in flight in the sync chains are lost. No overflow is generated on reset.
- grant_id value outside GRANT is don't-care to consumers, but the design holds its last value.

Test Plan:
- NUM_REQ=4, SYNC_STAGES=3, grant_ready=1: async_req[2] rises before edge 1 -> pending[2]=1 after edge 4; grant_valid=1, grant_id=2 after edge 5; grant_valid=0 and pending[2]=0 after edge 6.
- All four async_req rise together, grant_ready=1 -> grants 0,1,2,3 in order, each grant_valid high 1 cycle with 1 idle cycle between; a new event on req 0 afterwards is granted next (last_grant=3 wraps).
- grant_ready=0; async_req[1] pulses twice (4 cycles high, 4 low, 4 high) -> pending[1]=1, overflow[1] one-cycle pulse once; then grant_ready=1 -> exactly one grant with grant_id=1, pending[1]=0.
- Hold grant for req 0 with grant_ready=0. Time a second req 0 rise so rise[0] coincides with the acceptance cycle -> pending[0] remains 1, overflow[0]=0, a second grant_id=0 follows after one IDLE cycle.
- Starvation check: req 3 pending while reqs 0-2 re-raise continuously -> req 3 granted within 4 grants.
- Assert rst_n=0 while grant_valid=1, pending=4'b1010, async_req[0] mid-chain -> grant_valid, pending and overflow go to 0 immediately. After release with async_req=0, no grant appears. async_req[3] held high through release -> exactly one grant_id=3.
